// File: rtl/fft_r22sdf_pkg.sv
// Shared types, constants and elaboration-time helpers
// for the R2^2 SDF twiddle generators.
package fft_r22sdf_pkg;

    localparam int LOG2N_D = 10;
    localparam int LOG2L_D = 4;
    localparam int TW_W_D  = 10;
    localparam int N       = 1 << LOG2N_D;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    function automatic logic [1:0] bitrev2(input logic [1:0] a);
        return {a[0], a[1]};
    endfunction

    // cos samples are non-negative, so +0.5 then truncate rounds half away from zero
    function automatic int cos_mag(input int x, input int log2n, input int tw_w);
        real half;
        real v;
        half = real'((1 << log2n) / 2);
        v = real'(1 << (tw_w - 1)) * $cos(3.141592653589793 * real'(x) / half);
        return $rtoi(v + 0.5);
    endfunction

endpackage

// File: rtl/fft_quarter_cos_rom.sv
// Dual-read synchronous quarter-wave cosine magnitude ROM,
// N/4+1 entries, contents computed at elaboration.
module fft_quarter_cos_rom
    import fft_r22sdf_pkg::*;
#(
    parameter int LOG2N = LOG2N_D,
    parameter int TW_W  = TW_W_D
) (
    input  logic             clk,
    input  logic [LOG2N-2:0] addr_a,
    input  logic [LOG2N-2:0] addr_b,
    output logic [TW_W-1:0]  dout_a,
    output logic [TW_W-1:0]  dout_b
);

    localparam int DEPTH = (1 << LOG2N) / 4 + 1;

    function automatic logic [DEPTH*TW_W-1:0] fill();
        logic [DEPTH*TW_W-1:0] t;
        t = '0;
        for (int x = 0; x < DEPTH; x++) begin
            t[x*TW_W +: TW_W] = TW_W'(cos_mag(x, LOG2N, TW_W));
        end
        return t;
    endfunction

    localparam logic [DEPTH*TW_W-1:0] TABLE = fill();

    always_ff @(posedge clk) begin
        dout_a <= TABLE[int'(addr_a)*TW_W +: TW_W];
        dout_b <= TABLE[int'(addr_b)*TW_W +: TW_W];
    end

endmodule

// File: rtl/fft_r22sdf_twiddle_gen.sv
// Twiddle generator for one R2^2 SDF stage: index counter,
// exponent, quarter-wave fold and signed output, 3-cycle pipe.
module fft_r22sdf_twiddle_gen
    import fft_r22sdf_pkg::*;
#(
    parameter int LOG2N = LOG2N_D,
    parameter int LOG2L = LOG2L_D,
    parameter int TW_W  = TW_W_D
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cnt_clr,
    input  logic            in_vld,
    input  logic            inv,
    output logic [TW_W-1:0] tf_re,
    output logic [TW_W-1:0] tf_im,
    output logic            tf_vld,
    output logic            tf_last
);

    localparam int AW = LOG2N - 1;
    localparam int SH = LOG2N - LOG2L;
    localparam logic [AW-1:0] QTR = AW'(1 << (LOG2N - 2));
    localparam logic [TW_W-1:0] MAXP = {1'b0, {(TW_W-1){1'b1}}};

    logic [LOG2L-1:0] c;
    logic [LOG2L-1:0] issued;
    logic [1:0]       a;
    logic [LOG2L-3:0] b;
    logic [LOG2L-1:0] prod;
    logic [LOG2N-1:0] k;

    assign issued = cnt_clr ? '0 : c;
    assign a      = issued[LOG2L-1 -: 2];
    assign b      = issued[LOG2L-3:0];
    assign prod   = LOG2L'(bitrev2(a)) * LOG2L'(b);
    assign k      = LOG2N'(prod) << SH;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c <= '0;
        end else if (in_vld) begin
            c <= issued + LOG2L'(1);
        end else if (cnt_clr) begin
            c <= '0;
        end
    end

    logic             v1;
    logic [LOG2N-1:0] k1;
    logic             inv1;
    logic             last1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            k1    <= '0;
            inv1  <= 1'b0;
            last1 <= 1'b0;
        end else begin
            v1 <= in_vld;
            if (in_vld) begin
                k1    <= k;
                inv1  <= inv;
                last1 <= &issued;
            end
        end
    end

    logic [1:0]      q1;
    logic [AW-1:0]   addr_a;
    logic [AW-1:0]   addr_b;
    logic [TW_W-1:0] mag_c;
    logic [TW_W-1:0] mag_s;
    logic            re_neg;
    logic            im_neg;

    assign q1     = k1[LOG2N-1 -: 2];
    assign addr_a = {1'b0, k1[LOG2N-3:0]};
    assign addr_b = QTR - {1'b0, k1[LOG2N-3:0]};

    fft_quarter_cos_rom #(
        .LOG2N (LOG2N),
        .TW_W  (TW_W)
    ) u_rom (
        .clk    (clk),
        .addr_a (addr_a),
        .addr_b (addr_b),
        .dout_a (mag_c),
        .dout_b (mag_s)
    );

    always_comb begin
        re_neg = 1'b0;
        im_neg = 1'b0;
        unique case (1'b1)
            (q1 == Q0): begin re_neg = 1'b0; im_neg = 1'b1; end
            (q1 == Q1): begin re_neg = 1'b1; im_neg = 1'b1; end
            (q1 == Q2): begin re_neg = 1'b1; im_neg = 1'b0; end
            (q1 == Q3): begin re_neg = 1'b0; im_neg = 1'b0; end
        endcase
    end

    logic       v2;
    logic [1:0] q2;
    logic       re_neg2;
    logic       im_neg2;
    logic       last2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2      <= 1'b0;
            q2      <= '0;
            re_neg2 <= 1'b0;
            im_neg2 <= 1'b0;
            last2   <= 1'b0;
        end else begin
            v2      <= v1;
            q2      <= q1;
            re_neg2 <= re_neg;
            im_neg2 <= im_neg ^ inv1;
            last2   <= last1;
        end
    end

    // only a positive full-scale can overflow; -1.0 is representable
    function automatic logic [TW_W-1:0] sat(input logic neg, input logic [TW_W-1:0] m);
        if (neg) return ~m + TW_W'(1);
        return (m > MAXP) ? MAXP : m;
    endfunction

    logic [TW_W-1:0] mag_re;
    logic [TW_W-1:0] mag_im;

    assign mag_re = q2[0] ? mag_s : mag_c;
    assign mag_im = q2[0] ? mag_c : mag_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tf_re   <= '0;
            tf_im   <= '0;
            tf_vld  <= 1'b0;
            tf_last <= 1'b0;
        end else begin
            tf_vld  <= v2;
            tf_last <= v2 & last2;
            if (v2) begin
                tf_re <= sat(re_neg2, mag_re);
                tf_im <= sat(im_neg2, mag_im);
            end
        end
    end

endmodule

// File: tb/tb_fft_r22sdf_twiddle_gen.sv
// Directed table-driven bench for the twiddle generator,
// plus a small-N sweep against a real-valued golden model.
module tb_fft_r22sdf_twiddle_gen;

    logic       clk;
    logic       rst_n;
    logic       cnt_clr;
    logic       in_vld;
    logic       inv;
    logic [9:0] tf_re;
    logic [9:0] tf_im;
    logic       tf_vld;
    logic       tf_last;

    logic        in_vld6;
    logic        inv6;
    logic        clr6;
    logic [11:0] tf_re6;
    logic [11:0] tf_im6;
    logic        tf_vld6;
    logic        tf_last6;

    fft_r22sdf_twiddle_gen #(.LOG2N(10), .LOG2L(4), .TW_W(10)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cnt_clr (cnt_clr),
        .in_vld  (in_vld),
        .inv     (inv),
        .tf_re   (tf_re),
        .tf_im   (tf_im),
        .tf_vld  (tf_vld),
        .tf_last (tf_last)
    );

    fft_r22sdf_twiddle_gen #(.LOG2N(6), .LOG2L(6), .TW_W(12)) dut6 (
        .clk     (clk),
        .rst_n   (rst_n),
        .cnt_clr (clr6),
        .in_vld  (in_vld6),
        .inv     (inv6),
        .tf_re   (tf_re6),
        .tf_im   (tf_im6),
        .tf_vld  (tf_vld6),
        .tf_last (tf_last6)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic vld;
        int   re;
        int   im;
        logic last;
    } exp_t;

    typedef struct {
        int   gap;
        logic inv;
        int   idx;
        int   re;
        int   im;
        logic last;
    } row_t;

    int   checks;
    int   errors;
    exp_t pipe [4];
    int   hold_re;
    int   hold_im;
    int   base_re [16];
    int   base_im [16];
    row_t rows [48];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic clear_pipe();
        for (int s = 0; s < 4; s++) pipe[s] = '{1'b0, 0, 0, 1'b0};
        hold_re = 0;
        hold_im = 0;
    endtask

    task automatic tick(input logic v, input logic i, input logic c,
                        input int ere, input int eim, input logic elast);
        in_vld  = v;
        inv     = i;
        cnt_clr = c;
        for (int s = 3; s > 0; s--) pipe[s] = pipe[s-1];
        pipe[0] = '{v, ere, eim, elast};
        @(negedge clk);
        chk("tf_vld", int'(tf_vld), int'(pipe[3].vld));
        if (pipe[3].vld) begin
            hold_re = pipe[3].re;
            hold_im = pipe[3].im;
        end
        chk("tf_last", int'(tf_last), int'(pipe[3].vld & pipe[3].last));
        chk("tf_re", int'($signed(tf_re)), hold_re);
        chk("tf_im", int'($signed(tf_im)), hold_im);
        @(posedge clk);
        #1;
    endtask

    function automatic int conj_im(input int im);
        return (-im > 511) ? 511 : -im;
    endfunction

    task automatic issue(input int idx, input logic i, input logic c);
        tick(1'b1, i, c, base_re[idx], i ? conj_im(base_im[idx]) : base_im[idx], idx == 15);
    endtask

    task automatic idle(input logic c);
        tick(1'b0, 1'b0, c, 0, 0, 1'b0);
    endtask

    function automatic int rnd(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    initial begin
        int n;
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        cnt_clr = 1'b0;
        in_vld  = 1'b0;
        inv     = 1'b0;
        in_vld6 = 1'b0;
        inv6    = 1'b0;
        clr6    = 1'b0;
        clear_pipe();

        base_re = '{511, 511, 511, 511, 511, 362, 0, -362,
                    511, 473, 362, 196, 511, 196, -362, -473};
        base_im = '{0, 0, 0, 0, 0, -362, -512, -362,
                    0, -196, -362, -473, 0, -473, -362, 196};

        n = 0;
        for (int r = 0; r < 16; r++) begin
            rows[n] = '{0, 1'b0, r, 0, 0, 1'b0};
            n++;
        end
        for (int r = 0; r < 20; r++) begin
            rows[n] = '{(r == 0) ? 0 : (r % 3) + 1, 1'b0, r % 16, 0, 0, 1'b0};
            n++;
        end
        for (int r = 4; r < 16; r++) begin
            rows[n] = '{0, (r == 6 || r == 15), r, 0, 0, 1'b0};
            n++;
        end
        for (int r = 0; r < n; r++) begin
            rows[r].re   = base_re[rows[r].idx];
            rows[r].im   = rows[r].inv ? conj_im(base_im[rows[r].idx]) : base_im[rows[r].idx];
            rows[r].last = (rows[r].idx == 15);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_vld", int'(tf_vld), 0);
        chk("rst_last", int'(tf_last), 0);
        chk("rst_re", int'($signed(tf_re)), 0);
        chk("rst_im", int'($signed(tf_im)), 0);
        chk("rst_vld6", int'(tf_vld6), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int r = 0; r < n; r++) begin
            for (int g = 0; g < rows[r].gap; g++) idle(1'b0);
            tick(1'b1, rows[r].inv, 1'b0, rows[r].re, rows[r].im, rows[r].last);
        end
        repeat (3) idle(1'b0);

        for (int i = 0; i < 9; i++) issue(i, 1'b0, 1'b0);
        issue(0, 1'b0, 1'b1);
        issue(1, 1'b0, 1'b0);
        for (int i = 2; i < 5; i++) issue(i, 1'b0, 1'b0);
        idle(1'b1);
        issue(0, 1'b0, 1'b0);
        repeat (3) idle(1'b0);

        issue(1, 1'b0, 1'b0);
        issue(2, 1'b0, 1'b0);
        in_vld = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_vld", int'(tf_vld), 0);
        chk("arst_re", int'($signed(tf_re)), 0);
        chk("arst_im", int'($signed(tf_im)), 0);
        clear_pipe();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (4) idle(1'b0);
        for (int i = 0; i < 6; i++) issue(i, 1'b0, 1'b0);
        repeat (3) idle(1'b0);

        for (int t = 0; t < 67; t++) begin
            in_vld6 = (t < 64);
            @(negedge clk);
            chk("vld6", int'(tf_vld6), int'(t >= 3));
            if (t >= 3) begin
                int i6, a6, br6, k6, ere, eim;
                real ang;
                i6  = t - 3;
                a6  = i6 >> 4;
                br6 = ((a6 & 1) << 1) | (a6 >> 1);
                k6  = br6 * (i6 & 15);
                ang = 2.0 * 3.141592653589793 * real'(k6) / 64.0;
                ere = rnd(2048.0 * $cos(ang));
                eim = rnd(-2048.0 * $sin(ang));
                if (ere > 2047) ere = 2047;
                if (eim > 2047) eim = 2047;
                checks++;
                if (int'($signed(tf_re6)) < ere - 1 || int'($signed(tf_re6)) > ere + 1) begin
                    errors++;
                    $display("FAIL re6[%0d] actual=%0d required=%0d+/-1", i6, $signed(tf_re6), ere);
                end
                checks++;
                if (int'($signed(tf_im6)) < eim - 1 || int'($signed(tf_im6)) > eim + 1) begin
                    errors++;
                    $display("FAIL im6[%0d] actual=%0d required=%0d+/-1", i6, $signed(tf_im6), eim);
                end
                chk("last6", int'(tf_last6), int'(i6 == 63));
            end
            @(posedge clk);
            #1;
        end
        in_vld6 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
